// File: rtl/pattern_count_engine_if.sv
// Data-memory port shared by the pattern-count engine (master) and the memory (slave).
// Synchronous read: rdata is valid the cycle after rd_en.
interface pattern_count_engine_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (output rd_en, raddr, wr_en, waddr, wdata, input rdata);
  modport slave  (input rd_en, raddr, wr_en, waddr, wdata, output rdata);
endinterface

// File: rtl/pattern_count_engine.sv
// Pattern search accelerator: reads a pattern and NBYTES message words, counts in-byte,
// matching-byte and full-stream matches, then writes the three counts back to memory.
module pattern_count_engine #(
  parameter int unsigned PAT_W    = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NBYTES   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned RES_BASE = 33,
  localparam int unsigned CNT_W   = $clog2(NBYTES*DATA_W+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          done,
  output logic                          busy,
  pattern_count_engine_if.master        mem,
  output logic [CNT_W-1:0]              cnt_inbyte,
  output logic [CNT_W-1:0]              cnt_bytes,
  output logic [CNT_W-1:0]              cnt_cross
);

  localparam int unsigned HW    = $clog2(DATA_W+1);
  localparam int unsigned IDX_W = $clog2(NBYTES);
  localparam int unsigned NIN   = DATA_W - PAT_W + 1;
  localparam int unsigned SW    = (CNT_W > DATA_W) ? CNT_W : DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_PAT, S_SCAN, S_WR0, S_WR1, S_WR2, S_DONE
  } state_t;

  state_t              state;
  logic [PAT_W-1:0]    pat;
  logic [DATA_W-1:0]   prev;
  logic                have_prev;
  logic                pat_ld;
  logic                eval_vld;
  logic [IDX_W-1:0]    rd_idx;

  logic [2*DATA_W-1:0] win;
  logic [HW-1:0]       inb;
  logic [HW-1:0]       crs;
  logic [CNT_W-1:0]    nxt_inbyte;
  logic [CNT_W-1:0]    nxt_bytes;
  logic [CNT_W-1:0]    nxt_cross;

  // Clamp a count to the largest value a memory word can hold.
  function automatic logic [DATA_W-1:0] sat(input logic [CNT_W-1:0] c);
    logic [SW-1:0] cw;
    cw = SW'(c);
    if (cw > SW'({DATA_W{1'b1}})) return '1;
    return cw[DATA_W-1:0];
  endfunction

  // Per-word popcounts: low NIN windows lie inside the current word, the rest span into prev.
  always_comb begin
    win = {prev, mem.rdata};
    inb = '0;
    crs = '0;
    for (int unsigned k = 0; k < NIN; k++)
      if (win[k +: PAT_W] == pat) inb = inb + HW'(1);
    for (int unsigned k = NIN; k < DATA_W; k++)
      if (have_prev && (win[k +: PAT_W] == pat)) crs = crs + HW'(1);
    nxt_inbyte = cnt_inbyte + CNT_W'(inb);
    nxt_bytes  = cnt_bytes + CNT_W'(inb != '0);
    nxt_cross  = cnt_cross + CNT_W'(inb) + CNT_W'(crs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      busy       <= 1'b0;
      mem.rd_en  <= 1'b0;
      mem.raddr  <= '0;
      mem.wr_en  <= 1'b0;
      mem.waddr  <= '0;
      mem.wdata  <= '0;
      cnt_inbyte <= '0;
      cnt_bytes  <= '0;
      cnt_cross  <= '0;
      pat        <= '0;
      prev       <= '0;
      have_prev  <= 1'b0;
      pat_ld     <= 1'b0;
      eval_vld   <= 1'b0;
      rd_idx     <= '0;
    end else begin
      pat_ld <= 1'b0;
      if (pat_ld) pat <= mem.rdata[DATA_W-1 -: PAT_W];

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RD_PAT;
            busy       <= 1'b1;
            done       <= 1'b0;
            cnt_inbyte <= '0;
            cnt_bytes  <= '0;
            cnt_cross  <= '0;
            have_prev  <= 1'b0;
            eval_vld   <= 1'b0;
            mem.rd_en  <= 1'b1;
            mem.raddr  <= ADDR_W'(PAT_ADDR);
          end
        end
        S_RD_PAT: begin
          state     <= S_SCAN;
          pat_ld    <= 1'b1;
          mem.raddr <= ADDR_W'(MSG_BASE);
          rd_idx    <= '0;
        end
        S_SCAN: begin
          eval_vld <= mem.rd_en;
          if (mem.rd_en) begin
            if (rd_idx == IDX_W'(NBYTES-1)) begin
              mem.rd_en <= 1'b0;
            end else begin
              mem.raddr <= mem.raddr + ADDR_W'(1);
              rd_idx    <= rd_idx + IDX_W'(1);
            end
          end
          if (eval_vld) begin
            cnt_inbyte <= nxt_inbyte;
            cnt_bytes  <= nxt_bytes;
            cnt_cross  <= nxt_cross;
            prev       <= mem.rdata;
            have_prev  <= 1'b1;
          end
          // Last word evaluates the cycle after reads stop; its sum feeds the first write.
          if (eval_vld && !mem.rd_en) begin
            state     <= S_WR0;
            mem.wr_en <= 1'b1;
            mem.waddr <= ADDR_W'(RES_BASE);
            mem.wdata <= sat(nxt_inbyte);
          end
        end
        S_WR0: begin
          state     <= S_WR1;
          mem.waddr <= ADDR_W'(RES_BASE + 1);
          mem.wdata <= sat(cnt_bytes);
        end
        S_WR1: begin
          state     <= S_WR2;
          mem.waddr <= ADDR_W'(RES_BASE + 2);
          mem.wdata <= sat(cnt_cross);
        end
        S_WR2: begin
          state     <= S_DONE;
          mem.wr_en <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed bench for pattern_count_engine: vector table of message/pattern fills with
// hand-computed counts, plus mid-run restart, mid-run reset and count saturation sequences.
module tb_pattern_count_engine;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned NB  = 32;
  localparam int unsigned NB2 = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic done, busy, done2, busy2;
  logic [8:0] ci, cb, cc;
  logic [9:0] ci2, cb2, cc2;

  always #5 clk = ~clk;

  pattern_count_engine_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
  pattern_count_engine_if #(.ADDR_W(AW), .DATA_W(DW)) m2 ();

  pattern_count_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
    .mem(m1), .cnt_inbyte(ci), .cnt_bytes(cb), .cnt_cross(cc)
  );

  pattern_count_engine #(.NBYTES(NB2), .PAT_ADDR(64), .RES_BASE(65)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .done(done2), .busy(busy2),
    .mem(m2), .cnt_inbyte(ci2), .cnt_bytes(cb2), .cnt_cross(cc2)
  );

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic       ld_go = 1'b0;
  logic       ld2_go = 1'b0;
  logic [7:0] ld_fill = 8'h00, ld_w0 = 8'h00, ld_w1 = 8'h00, ld_pat = 8'h00, ld_res = 8'h00;
  int         wr_cnt1 = 0;
  bit         overlap = 1'b0;
  int         tests = 0;
  int         fails = 0;

  // Memory models: synchronous read, bench preload takes priority over engine writes.
  always @(posedge clk) begin
    if (m1.rd_en) m1.rdata <= mem1[m1.raddr];
    if (m1.rd_en && m1.wr_en) overlap <= 1'b1;
    if (ld_go) begin
      for (int j = 0; j < 256; j++)
        mem1[j] <= (j == 0) ? ld_w0 : (j == 1) ? ld_w1 : (j < 32) ? ld_fill :
                   (j == 32) ? ld_pat : (j >= 33 && j <= 35) ? ld_res : 8'h00;
    end else if (m1.wr_en) begin
      mem1[m1.waddr] <= m1.wdata;
      wr_cnt1 <= wr_cnt1 + 1;
    end
  end

  always @(posedge clk) begin
    if (m2.rd_en) m2.rdata <= mem2[m2.raddr];
    if (m2.rd_en && m2.wr_en) overlap <= 1'b1;
    if (ld2_go) begin
      for (int j = 0; j < 256; j++) mem2[j] <= 8'h00;
    end else if (m2.wr_en) begin
      mem2[m2.waddr] <= m2.wdata;
    end
  end

  typedef struct {
    logic [7:0] fill;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] pat;
    int         e_in;
    int         e_by;
    int         e_cr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load1(input vec_t v, input logic [7:0] res);
    @(negedge clk);
    ld_fill = v.fill; ld_w0 = v.w0; ld_w1 = v.w1; ld_pat = v.pat; ld_res = res;
    ld_go = 1'b1;
    @(negedge clk);
    ld_go = 1'b0;
  endtask

  // Pulses start, optionally re-pulses at edge count 'repulse_at', returns edges until done.
  task automatic start_and_wait(input int repulse_at, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    check("done_drop_on_accept", int'(done), 0);
    while (!done && lat < 300) begin
      start = (lat == repulse_at);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int repulse_at);
    int lat;
    load1(v, 8'h00);
    start_and_wait(repulse_at, lat);
    check({tag, "_latency"}, lat, NB + 6);
    check({tag, "_cnt_inbyte"}, int'(ci), v.e_in);
    check({tag, "_cnt_bytes"}, int'(cb), v.e_by);
    check({tag, "_cnt_cross"}, int'(cc), v.e_cr);
    check({tag, "_mem33"}, int'(mem1[33]), v.e_in);
    check({tag, "_mem34"}, int'(mem1[34]), v.e_by);
    check({tag, "_mem35"}, int'(mem1[35]), v.e_cr);
    check({tag, "_busy_in_done"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    int wsnap;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 252};
    vecs[1] = '{8'h55, 8'h55, 8'h55, 8'hA8,  64, 32, 126};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hF8, 128, 32, 252};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'hF8,   0,  0,   0};
    vecs[4] = '{8'h00, 8'h07, 8'hC0, 8'hF8,   0,  0,   1};
    vecs[5] = '{8'hAA, 8'hAA, 8'hAA, 8'hA8,  64, 32, 126};
    vecs[6] = '{8'h00, 8'hF8, 8'h00, 8'hF8,   1,  1,   1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rd_en", int'(m1.rd_en), 0);
    check("reset_wr_en", int'(m1.wr_en), 0);
    check("reset_raddr", int'(m1.raddr), 0);
    check("reset_cnt_cross", int'(cc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // Restart request during SCAN must be ignored.
    run_vec("repulse", vecs[1], 10);

    // Reset during SCAN: immediate abort, result words untouched.
    load1(vecs[0], 8'hEE);
    wsnap = wr_cnt1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rd_en", int'(m1.rd_en), 0);
    check("abort_cnt_cross", int'(cc), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_writes", wr_cnt1 - wsnap, 0);
    check("abort_mem33", int'(mem1[33]), 8'hEE);
    check("abort_mem35", int'(mem1[35]), 8'hEE);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_abort", vecs[2], 0);

    // NBYTES=64 all-zero stream: port counts exceed a byte, memory copies saturate.
    @(negedge clk);
    ld2_go = 1'b1;
    @(negedge clk);
    ld2_go = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done2) check("sat_done_timeout", 0, 1);
    check("sat_latency", lat, NB2 + 6);
    check("sat_cnt_inbyte", int'(ci2), 256);
    check("sat_cnt_bytes", int'(cb2), 64);
    check("sat_cnt_cross", int'(cc2), 508);
    check("sat_mem65", int'(mem2[65]), 255);
    check("sat_mem66", int'(mem2[66]), 64);
    check("sat_mem67", int'(mem2[67]), 255);

    check("rd_wr_overlap", int'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
